led_fill_drain: RTL and testbench
=================================

// Module: led_fill_drain
// PURPOSE
//   Complementary LED pattern engine to the drain-only shifter. It lights LEDs one at a
//   time until all are on (FILL), holds, then extinguishes them one at a time (DRAIN),
//   rests, and repeats.
//   Steps are paced by an internal prescaler, so the block drives board LEDs directly
//   from the system clock.
//   Fill/drain direction is selectable at run time.
// PARAMETERS
//   WIDTH       8           number of LEDs; must be >= 2
//   DIV         25_000_000  clk cycles per step; must be >= 1 (DIV=1: step every cycle)
//   HOLD_STEPS  2           steps spent in HOLD and in GAP; must be >= 1
// PORTS
//   clk    in   1      system clock; all state updates on its rising edge
//   rs     in   1      reset, asynchronous, active-high
//   en     in   1      1 = run; 0 = freeze prescaler, FSM and LEDs
//   dir    in   1      0 = shift toward MSB (new bit enters at LSB); 1 = toward LSB (new bit at MSB)
//   led    out  WIDTH  LED drive pattern, registered
//   phase  out  2      current state: 0=FILL 1=HOLD 2=DRAIN 3=GAP, registered
//   step   out  1      one-cycle pulse on every prescaler step (qualified by en)
// BEHAVIOUR
// - Reset (rs=1, asynchronous): led=0, phase=FILL, step=0, prescaler=0, hold counter=0.
//   While rs is high, all outputs stay at these values.
// - Prescaler: counts 0..DIV-1 while en=1. It wraps to 0 when it reaches DIV-1.
//   The internal tick is asserted in the cycle where count==DIV-1 and en=1.
//   The step output is the tick registered, so it is high the cycle after the tick.
//   It coincides with the led/phase update.
// - en=0: prescaler count, FSM, hold counter and led all hold their values.
//   Re-asserting en resumes from the same count, so no step is lost or duplicated.
// - dir is sampled only at a tick. A change takes effect on the next step, and the FSM
//   is not reset.
// - FSM transitions happen only at a tick:
//   - FILL: shift in a 1 (dir=0: {led[W-2:0],1}; dir=1: {1,led[W-1:1]}).
//     If the new value is all-ones, go to HOLD and clear the hold counter.
//   - HOLD: increment the hold counter. At HOLD_STEPS-1, go to DRAIN and clear the counter.
//     led is unchanged.
//   - DRAIN: shift in a 0 using the same direction rule.
//     If the new value is zero, go to GAP and clear the counter.
//   - GAP: increment the hold counter. At HOLD_STEPS-1, go to FILL and clear the counter.
//     led stays 0.
// - A dir change mid-FILL can leave holes (e.g. 0x03 then 0x81). FILL still ends only
//   when led == all-ones, and DRAIN ends only when led == 0.
//   Completion is guaranteed within WIDTH more steps of constant dir.
// - Full period with constant dir: (2*WIDTH + 2*HOLD_STEPS) * DIV clk cycles.
// - rs asserted mid-operation: immediate return to the reset values, with no wait for a
//   tick. After rs deasserts, the first step occurs DIV cycles later.
// - The prescaler counter width is max(1, clog2(DIV)). It must never count past DIV-1.
// TESTING  (WIDTH=8, DIV=4, HOLD_STEPS=2)
//   1. rs=1 pulsed mid-count -> led=0x00, phase=0, step=0 immediately, before any clk edge.
//   2. en=1, dir=0 from reset -> one step every 4 clks. led goes 01,03,07,...,FF.
//      phase becomes 1 on the 8th step.
//   3. Continue -> 2 steps with FF held, then phase=2. led goes FE,FC,...,00 (8 steps).
//      Then phase=3 for 2 steps, then phase=0. Second FF is reached at clk 4*(20+8).
//   4. dir=1 from reset -> led 80,C0,E0,...,FF. Drain gives 7F,3F,...,00.
//   5. en=0 for 10 clks after the 3rd FILL step, with count=1 -> led=0x07 and no step
//      pulses while frozen. The 4th step (0x0F) arrives 3 clks after en returns to 1.
//   6. DIV=1 build -> step is high every cycle, and led changes every clk, following
//      the same sequence as test 2.

Source files
------------

// File: rtl/led_fill_drain_if.sv
// led_fill_drain_if: run/direction controls and LED/phase/step outputs of the pattern engine
interface led_fill_drain_if #(parameter int WIDTH = 8);
  logic en;
  logic dir;
  logic [WIDTH-1:0] led;
  logic [1:0] phase;
  logic step;
  modport master(output en, dir, input led, phase, step);
  modport slave(input en, dir, output led, phase, step);
endinterface

// File: rtl/led_fill_drain.sv
// led_fill_drain: prescaled FILL/HOLD/DRAIN/GAP LED pattern engine with run-time direction
module led_fill_drain #(
  parameter int WIDTH = 8,
  parameter int DIV = 25_000_000,
  parameter int HOLD_STEPS = 2
) (
  input logic clk,
  input logic rs,
  led_fill_drain_if.slave bus
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int HW = HOLD_STEPS > 1 ? $clog2(HOLD_STEPS) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_STEPS - 1);
  typedef enum logic [1:0] {FILL, HOLD, DRAIN, GAP} state_t;
  state_t st;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hc;
  logic tick;
  logic [WIDTH-1:0] fill_v, drain_v;
  assign tick = bus.en && cnt == C_LAST;
  assign fill_v = bus.dir ? {1'b1, bus.led[WIDTH-1:1]} : {bus.led[WIDTH-2:0], 1'b1};
  assign drain_v = bus.dir ? {1'b0, bus.led[WIDTH-1:1]} : {bus.led[WIDTH-2:0], 1'b0};
  assign bus.phase = st;
  always_ff @(posedge clk or posedge rs)
    if (rs) begin
      cnt <= '0;
      hc <= '0;
      st <= FILL;
      bus.led <= '0;
      bus.step <= 1'b0;
    end else begin
      bus.step <= tick;
      if (bus.en) cnt <= cnt == C_LAST ? '0 : cnt + 1'b1;
      if (tick)
        case (st)
          FILL: begin
            bus.led <= fill_v;
            if (&fill_v) begin
              st <= HOLD;
              hc <= '0;
            end
          end
          HOLD: begin
            st <= hc == H_LAST ? DRAIN : HOLD;
            hc <= hc == H_LAST ? '0 : hc + 1'b1;
          end
          DRAIN: begin
            bus.led <= drain_v;
            if (drain_v == '0) begin
              st <= GAP;
              hc <= '0;
            end
          end
          default: begin
            st <= hc == H_LAST ? FILL : GAP;
            hc <= hc == H_LAST ? '0 : hc + 1'b1;
          end
        endcase
    end
endmodule

// File: tb/tb_led_fill_drain.sv
// tb_led_fill_drain: scoreboard bench for the LED fill/drain engine (DIV=4 and DIV=1 builds)
module tb_led_fill_drain;
  localparam int HS = 2;
  logic clk = 1'b0;
  logic rs = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic [9:0] q[$];
  logic [9:0] e;
  logic [7:0] m_led;
  logic [1:0] m_ph;
  int m_hc;
  led_fill_drain_if #(.WIDTH(8)) bus();
  led_fill_drain_if #(.WIDTH(8)) bus1();
  led_fill_drain #(.WIDTH(8), .DIV(4), .HOLD_STEPS(HS)) dut (.clk(clk), .rs(rs), .bus(bus));
  led_fill_drain #(.WIDTH(8), .DIV(1), .HOLD_STEPS(HS)) dut1 (.clk(clk), .rs(rs), .bus(bus1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_led = 8'h00;
    m_ph = 2'd0;
    m_hc = 0;
  endtask
  task automatic model_step(input logic d);
    case (m_ph)
      2'd0: begin
        m_led = d ? {1'b1, m_led[7:1]} : {m_led[6:0], 1'b1};
        if (m_led == 8'hFF) begin
          m_ph = 2'd1;
          m_hc = 0;
        end
      end
      2'd1: if (m_hc == HS - 1) begin
        m_ph = 2'd2;
        m_hc = 0;
      end else m_hc++;
      2'd2: begin
        m_led = d ? {1'b0, m_led[7:1]} : {m_led[6:0], 1'b0};
        if (m_led == 8'h00) begin
          m_ph = 2'd3;
          m_hc = 0;
        end
      end
      default: if (m_hc == HS - 1) begin
        m_ph = 2'd0;
        m_hc = 0;
      end else m_hc++;
    endcase
  endtask
  task automatic wait_step(input int gap);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.step && n < gap + 8);
    cyc += n;
    chk("step_gap", n, gap);
  endtask
  task automatic do_step(input int gap);
    model_step(bus.dir);
    q.push_back({m_ph, m_led});
    wait_step(gap);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rs = 1'b1;
    @(negedge clk);
    rs = 1'b0;
    q.delete();
    model_reset();
    cyc = 0;
  endtask
  always @(negedge clk)
    if (bus.step) begin
      if (q.size() == 0) chk("spurious_step", 1, 0);
      else begin
        e = q.pop_front();
        chk("sb_out", {22'd0, bus.phase, bus.led}, {22'd0, e});
      end
    end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.en = 1'b0;
    bus.dir = 1'b0;
    bus1.en = 1'b0;
    bus1.dir = 1'b0;
    #1;
    chk("rst_led", bus.led, 8'h00);
    chk("rst_phase", bus.phase, 0);
    chk("rst_step", bus.step, 0);
    @(negedge clk);
    rs = 1'b0;
    bus.en = 1'b1;
    model_reset();
    for (int i = 0; i < 28; i++) begin
      do_step(4);
      if (i == 7) chk("fill_done_phase", bus.phase, 1);
    end
    chk("second_ff_cycle", cyc, 112);
    chk("second_ff_led", bus.led, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    #2 rs = 1'b1;
    #1;
    chk("async_rst_led", bus.led, 8'h00);
    chk("async_rst_phase", bus.phase, 0);
    chk("async_rst_step", bus.step, 0);
    @(negedge clk);
    rs = 1'b0;
    q.delete();
    model_reset();
    for (int i = 0; i < 3; i++) do_step(4);
    chk("pre_freeze_led", bus.led, 8'h07);
    @(negedge clk);
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("frozen_led", bus.led, 8'h07);
      chk("frozen_step", bus.step, 0);
    end
    bus.en = 1'b1;
    do_step(3);
    chk("resume_led", bus.led, 8'h0F);
    for (int i = 0; i < 4; i++) do_step(4);
    bus.dir = 1'b1;
    do_reset();
    do_step(4);
    chk("dir1_first", bus.led, 8'h80);
    for (int i = 0; i < 19; i++) do_step(4);
    for (int i = 0; i < 2; i++) do_step(4);
    bus.dir = 1'b0;
    do_step(4);
    chk("dir_change_hole", bus.led, 8'h81);
    for (int i = 0; i < 9; i++) do_step(4);
    bus.en = 1'b0;
    do_reset();
    bus1.en = 1'b1;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      model_step(1'b0);
      chk("div1_step", bus1.step, 1);
      chk("div1_out", {22'd0, bus1.phase, bus1.led}, {22'd0, m_ph, m_led});
    end
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
